// File: rtl/prog_load_mem_pkg.sv
// ============================================================================
// Module      : prog_load_mem_pkg
// Description : Shared types and constants for the program-loading word memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_load_mem_pkg;

  localparam int          DEPTH_DEFAULT  = 256;
  localparam int          DATA_W_DEFAULT = 16;
  localparam logic [15:0] FILL_WORD      = 16'h0000;

  typedef enum logic [1:0] {
    LD_LOAD_HI = 2'd0,
    LD_LOAD_LO = 2'd1,
    LD_FILL    = 2'd2,
    LD_RUN     = 2'd3
  } ldmem_state_t;

  function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_load_mem_word_ram.sv
// ============================================================================
// Module      : word_ram
// Description : DEPTH x DATA_W RAM, one write port and one registered read
//               port (read-first), no reset on contents or read register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/prog_load_mem.sv
// ============================================================================
// Module      : prog_load_mem
// Description : Loads a byte-stream program into word RAM while holding the
//               CPU in reset, then serves CPU reads/writes (1-cycle latency).
//               Optional macro MEM_ZERO_FILL_EN: zero unloaded words first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_load_mem
  import prog_load_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        load_done,
  output logic        load_err,
  output logic        cpu_rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  localparam logic [1:0] LOAD_HI = LD_LOAD_HI;
  localparam logic [1:0] LOAD_LO = LD_LOAD_LO;
`ifdef MEM_ZERO_FILL_EN
  localparam logic [1:0] FILL    = LD_FILL;
`endif
  localparam logic [1:0] RUN     = LD_RUN;

  localparam logic [PW-1:0] WPTR_MAX = PW'(DEPTH);

  logic [1:0]        state, state_nxt;
  logic [PW-1:0]     wptr, wptr_nxt, wptr_inc;
  logic [7:0]        hi_byte;
  logic              r_load_done, r_load_err, r_cpu_rst, r_rd_en;
  logic              w_fire, w_full, w_in_range, w_run;
  logic              ld_we, fill_we, cpu_wr, end_of_load;
  logic [DATA_W-1:0] ld_word;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign w_run      = (state == RUN);
  assign ld_ready   = rst && ((state == LOAD_HI) || (state == LOAD_LO));
  assign w_fire     = ld_valid && ld_ready;
  assign w_full     = (wptr == WPTR_MAX);
  assign wptr_inc   = w_full ? wptr : wptr + PW'(1);
  assign w_in_range = ({16'd0, cpu_addr} < 32'(DEPTH));

  always_comb begin
    state_nxt   = state;
    ld_we       = 1'b0;
    ld_word     = pack_word(ld_data, 8'h00);
    end_of_load = 1'b0;
    fill_we     = 1'b0;
    case (state)
      LOAD_HI: begin
        if (w_fire) begin
          if (ld_last) begin
            ld_we       = 1'b1;
            end_of_load = 1'b1;
          end else begin
            state_nxt = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (w_fire) begin
          ld_we   = 1'b1;
          ld_word = pack_word(hi_byte, ld_data);
          if (ld_last) begin
            end_of_load = 1'b1;
          end else begin
            state_nxt = LOAD_HI;
          end
        end
      end
`ifdef MEM_ZERO_FILL_EN
      FILL: begin
        fill_we = 1'b1;
        if (wptr_inc == WPTR_MAX) begin
          state_nxt = RUN;
        end
      end
`endif
      default: state_nxt = RUN;
    endcase
    // An overflowed load has nothing left to fill, so it skips FILL entirely.
    if (end_of_load) begin
`ifdef MEM_ZERO_FILL_EN
      state_nxt = (wptr_inc == WPTR_MAX) ? RUN : FILL;
`else
      state_nxt = RUN;
`endif
    end
  end

  always_comb begin
    wptr_nxt = wptr;
    if ((ld_we || fill_we) && !w_full) begin
      wptr_nxt = wptr_inc;
    end
  end

  // Loader, fill and CPU writes are mutually exclusive by state.
  assign cpu_wr    = w_run && cpu_we && w_in_range;
  assign ram_we    = (ld_we && !w_full) || fill_we || cpu_wr;
  assign ram_waddr = w_run ? cpu_addr[AW-1:0] : wptr[AW-1:0];
  assign ram_wdata = w_run ? cpu_wdata : (fill_we ? FILL_WORD : ld_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD_HI;
      wptr        <= '0;
      hi_byte     <= 8'h00;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_rd_en     <= 1'b0;
    end else begin
      state       <= state_nxt;
      wptr        <= wptr_nxt;
      if (w_fire && (state == LOAD_HI)) begin
        hi_byte <= ld_data;
      end
      r_load_done <= r_load_done || (state_nxt == RUN);
      r_load_err  <= r_load_err || (ld_we && w_full);
      r_cpu_rst   <= !w_run;
      r_rd_en     <= w_run && w_in_range;
    end
  end

  word_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cpu_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign cpu_rst   = r_cpu_rst;
  assign cpu_rdata = r_rd_en ? ram_rdata : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_prog_load_mem.sv
// ============================================================================
// Module      : tb_prog_load_mem
// Description : Self-checking bench for prog_load_mem (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_load_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_valid = 1'b0, a_last = 1'b0, a_we = 1'b0;
  logic [7:0]  a_data = 8'h00;
  logic [15:0] a_addr = 16'h0000, a_wdata = 16'h0000;
  logic        a_ready, a_done, a_err, a_cpu_rst;
  logic [15:0] a_rdata;

  logic        b_valid = 1'b0, b_last = 1'b0, b_we = 1'b0;
  logic [7:0]  b_data = 8'h00;
  logic [15:0] b_addr = 16'h0000, b_wdata = 16'h0000;
  logic        b_ready, b_done, b_err, b_cpu_rst;
  logic [15:0] b_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prog_load_mem #(.DEPTH(256)) dut_a (
    .clk(clk), .rst(rst),
    .ld_valid(a_valid), .ld_data(a_data), .ld_last(a_last), .ld_ready(a_ready),
    .load_done(a_done), .load_err(a_err), .cpu_rst(a_cpu_rst),
    .cpu_addr(a_addr), .cpu_we(a_we), .cpu_wdata(a_wdata), .cpu_rdata(a_rdata)
  );

  prog_load_mem #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .ld_valid(b_valid), .ld_data(b_data), .ld_last(b_last), .ld_ready(b_ready),
    .load_done(b_done), .load_err(b_err), .cpu_rst(b_cpu_rst),
    .cpu_addr(b_addr), .cpu_we(b_we), .cpu_wdata(b_wdata), .cpu_rdata(b_rdata)
  );

  typedef struct {
    bit          dut;   // 0 = DEPTH 256, 1 = DEPTH 4
    bit          chk;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input bit dut, input logic [7:0] d, input bit last, input int gap);
    int n;
    @(negedge clk);
    if (!dut) begin a_valid = 1'b1; a_data = d; a_last = last; end
    else      begin b_valid = 1'b1; b_data = d; b_last = last; end
    n = 0;
    while (!(dut ? b_ready : a_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL ld_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      if (!vecs[i].dut) begin a_addr = vecs[i].addr; a_we = vecs[i].we; a_wdata = vecs[i].wdata; end
      else              begin b_addr = vecs[i].addr; b_we = vecs[i].we; b_wdata = vecs[i].wdata; end
      @(posedge clk);
      #1;
      if (vecs[i].chk) check(vecs[i].name, vecs[i].dut ? b_rdata : a_rdata, vecs[i].exp);
    end
    @(negedge clk);
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         dut chk addr      we    wdata     exp       name
    vecs[0]  = '{0, 1, 16'h0000, 1'b0, 16'h0000, 16'hC12A, "t1_rd0"};
    vecs[1]  = '{0, 1, 16'h0001, 1'b0, 16'h0000, 16'h7777, "t1_rd1"};
    vecs[2]  = '{0, 0, 16'h0003, 1'b1, 16'h1234, 16'h0000, "prime3"};
    vecs[3]  = '{0, 1, 16'h0003, 1'b1, 16'hBEEF, 16'h1234, "rd_first"};
    vecs[4]  = '{0, 1, 16'h0003, 1'b0, 16'h0000, 16'hBEEF, "rd_after_wr"};
    vecs[5]  = '{0, 1, 16'h0100, 1'b1, 16'h5555, 16'h0000, "oor_wr"};
    vecs[6]  = '{0, 1, 16'h0100, 1'b0, 16'h0000, 16'h0000, "oor_rd"};
    vecs[7]  = '{0, 1, 16'h0000, 1'b0, 16'h0000, 16'hC12A, "oor_no_alias"};
    vecs[8]  = '{0, 1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, "oor_ffff"};
    vecs[9]  = '{0, 1, 16'h0000, 1'b0, 16'h0000, 16'h0805, "t3_rd0"};
    vecs[10] = '{0, 1, 16'h0001, 1'b0, 16'h0000, 16'hFF00, "t3_rd1_pad"};
    vecs[11] = '{0, 1, 16'h0000, 1'b0, 16'h0000, 16'hABCD, "t6_rd0"};
    vecs[12] = '{0, 1, 16'h0001, 1'b0, 16'h0000, 16'hFF00, "t6_rd1_kept"};
    vecs[13] = '{0, 1, 16'h0000, 1'b0, 16'h0000, 16'hC12A, "t2_rd0"};
    vecs[14] = '{0, 1, 16'h0001, 1'b0, 16'h0000, 16'h7777, "t2_rd1"};
    vecs[15] = '{1, 1, 16'h0000, 1'b0, 16'h0000, 16'h0102, "t4_rd0"};
    vecs[16] = '{1, 1, 16'h0001, 1'b0, 16'h0000, 16'h0304, "t4_rd1"};
    vecs[17] = '{1, 1, 16'h0002, 1'b0, 16'h0000, 16'h0506, "t4_rd2"};
    vecs[18] = '{1, 1, 16'h0003, 1'b0, 16'h0000, 16'h0708, "t4_rd3"};
    vecs[19] = '{1, 1, 16'h0004, 1'b0, 16'h0000, 16'h0000, "t4_oor"};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ld_ready", {15'd0, a_ready},   16'd0);
    check("rst_cpu_rst",  {15'd0, a_cpu_rst}, 16'd1);
    check("rst_done",     {15'd0, a_done},    16'd0);
    check("rst_err",      {15'd0, a_err},     16'd0);
    check("rst_rdata",    a_rdata,            16'h0000);
    rst = 1'b1;
    #1;
    check("t1_ready_load", {15'd0, a_ready}, 16'd1);

    // Test 1: contiguous load
    send(0, 8'hC1, 0, 0);
    send(0, 8'h2A, 0, 0);
    send(0, 8'h77, 0, 0);
    send(0, 8'h77, 1, 0);
    check("t1_done",        {15'd0, a_done},    16'd1);
    check("t1_ready_run",   {15'd0, a_ready},   16'd0);
    check("t1_cpu_rst_hold",{15'd0, a_cpu_rst}, 16'd1);
    check("t1_err",         {15'd0, a_err},     16'd0);
    @(posedge clk);
    #1;
    check("t1_cpu_rst_rel", {15'd0, a_cpu_rst}, 16'd0);
    run_vecs(0, 8);

    // Test 3: odd byte count, last on a high byte
    do_reset();
    send(0, 8'h08, 0, 0);
    send(0, 8'h05, 0, 0);
    send(0, 8'hFF, 1, 0);
    check("t3_done", {15'd0, a_done}, 16'd1);
    run_vecs(9, 10);

    // Test 6: reset mid-load, then a fresh 2-byte load
    do_reset();
    send(0, 8'h11, 0, 0);
    send(0, 8'h22, 0, 0);
    send(0, 8'h33, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready",   {15'd0, a_ready},   16'd0);
    check("t6_cpu_rst", {15'd0, a_cpu_rst}, 16'd1);
    check("t6_done",    {15'd0, a_done},    16'd0);
    check("t6_err",     {15'd0, a_err},     16'd0);
    @(negedge clk);
    rst = 1'b1;
    send(0, 8'hAB, 0, 0);
    send(0, 8'hCD, 1, 0);
    check("t6_done_new", {15'd0, a_done}, 16'd1);
    run_vecs(11, 12);

    // Test 2: same program with ld_valid toggled
    do_reset();
    send(0, 8'hC1, 0, 1);
    send(0, 8'h2A, 0, 1);
    send(0, 8'h77, 0, 1);
    send(0, 8'h77, 1, 1);
    check("t2_done", {15'd0, a_done}, 16'd1);
    run_vecs(13, 14);

    // Test 4: overflow on DEPTH=4
    for (int i = 1; i <= 10; i++) begin
      send(1, 8'(i), (i == 10), 0);
    end
    check("t4_err",  {15'd0, b_err},  16'd1);
    check("t4_done", {15'd0, b_done}, 16'd1);
    run_vecs(15, 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
